// File: rtl/ic_arbiter_if.sv
// Bundles the fetch/prefetch request ports, shared response and icache-side signals of ic_arbiter.
// slave = the arbiter's view; master = the surrounding core/icache driving it.
interface ic_arbiter_if;
  logic        f_rd_i;
  logic [31:0] f_pc_i;
  logic [1:0]  f_priv_i;
  logic        f_abort_i;
  logic        f_accept_o;
  logic        f_valid_o;
  logic        p_rd_i;
  logic [31:0] p_pc_i;
  logic [1:0]  p_priv_i;
  logic        p_abort_i;
  logic        p_accept_o;
  logic        p_valid_o;
  logic        flush_i;
  logic [31:0] rsp_inst_o;
  logic        rsp_error_o;
  logic        rsp_page_fault_o;
  logic        ic_rd_o;
  logic [31:0] ic_pc_o;
  logic [1:0]  ic_priv_o;
  logic        ic_flush_o;
  logic        ic_accept_i;
  logic        ic_valid_i;
  logic [31:0] ic_inst_i;
  logic        ic_error_i;
  logic        ic_page_fault_i;

  modport slave (
    input  f_rd_i, f_pc_i, f_priv_i, f_abort_i,
    output f_accept_o, f_valid_o,
    input  p_rd_i, p_pc_i, p_priv_i, p_abort_i,
    output p_accept_o, p_valid_o,
    input  flush_i,
    output rsp_inst_o, rsp_error_o, rsp_page_fault_o,
    output ic_rd_o, ic_pc_o, ic_priv_o, ic_flush_o,
    input  ic_accept_i, ic_valid_i, ic_inst_i, ic_error_i, ic_page_fault_i
  );

  modport master (
    output f_rd_i, f_pc_i, f_priv_i, f_abort_i,
    input  f_accept_o, f_valid_o,
    output p_rd_i, p_pc_i, p_priv_i, p_abort_i,
    input  p_accept_o, p_valid_o,
    output flush_i,
    input  rsp_inst_o, rsp_error_o, rsp_page_fault_o,
    input  ic_rd_o, ic_pc_o, ic_priv_o, ic_flush_o,
    output ic_accept_i, ic_valid_i, ic_inst_i, ic_error_i, ic_page_fault_i
  );
endinterface

// File: rtl/ic_arbiter.sv
// Two-port (fetch/prefetch) icache arbiter: one request in flight, combinational grant, response same cycle as ic_valid_i,
// flush holds ic_flush_o for FLUSH_CYCLES and blocks grants; ports wait on accept. IC_ARB_RR_EN enables round-robin.
module ic_arbiter #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  ic_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q;
  logic        owner_q;
  logic        drop_q;
  logic        flush_pend_q;
  logic [3:0]  cnt_q;
  logic        win;
  logic        any_req;
  logic        ic_rd;
  logic        take;
  logic        own_abort;
  logic        deliver;
  logic [31:0] win_pc;
  logic [1:0]  win_priv;

`ifdef IC_ARB_RR_EN
  logic rr_q;

  // rr_q names the port that wins the next tie (the one not granted last)
  always_comb begin
    win = 1'b0;
    if (bus.f_rd_i && bus.p_rd_i) win = rr_q;
    else                          win = !bus.f_rd_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_q <= 1'b0;
    else if (take) rr_q <= !win;
  end
`else
  always_comb win = !bus.f_rd_i;
`endif

  assign any_req   = bus.f_rd_i || bus.p_rd_i;
  // A flush in the same IDLE cycle beats any request
  assign ic_rd     = rst_n && (state_q == ST_IDLE) && !bus.flush_i && any_req;
  assign take      = ic_rd && bus.ic_accept_i;
  assign win_pc    = win ? bus.p_pc_i : bus.f_pc_i;
  assign win_priv  = win ? bus.p_priv_i : bus.f_priv_i;
  assign own_abort = owner_q ? bus.p_abort_i : bus.f_abort_i;
  assign deliver   = rst_n && (state_q == ST_BUSY) && bus.ic_valid_i && !drop_q && !own_abort;

  assign bus.ic_rd_o    = ic_rd;
  assign bus.ic_pc_o    = ic_rd ? (win_pc & 32'hFFFF_FFFC) : 32'h0;
  assign bus.ic_priv_o  = ic_rd ? win_priv : 2'b00;
  assign bus.ic_flush_o = rst_n && (state_q == ST_FLUSH);
  assign bus.f_accept_o = take && !win;
  assign bus.p_accept_o = take && win;
  assign bus.f_valid_o  = deliver && !owner_q;
  assign bus.p_valid_o  = deliver && owner_q;

  assign bus.rsp_inst_o       = rst_n ? bus.ic_inst_i : 32'h0;
  assign bus.rsp_error_o      = rst_n && bus.ic_error_i;
  assign bus.rsp_page_fault_o = rst_n && bus.ic_page_fault_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      drop_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.flush_i) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FLUSH_LOAD;
          end else if (take) begin
            state_q <= ST_BUSY;
            owner_q <= win;
            drop_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (own_abort)   drop_q       <= 1'b1;
          if (bus.flush_i) flush_pend_q <= 1'b1;
          // The response still completes; a pending or coincident flush follows it
          if (bus.ic_valid_i) begin
            if (flush_pend_q || bus.flush_i) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (bus.flush_i) begin
            cnt_q <= FLUSH_LOAD;
          end else if (cnt_q <= 4'd1) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            cnt_q        <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_arbiter.sv
// Directed bench for ic_arbiter: inputs driven just after posedge, outputs checked at negedge.
// Expectations follow the IC_ARB_RR_EN build setting.
module tb_ic_arbiter;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  ic_arbiter_if ifc ();

  ic_arbiter #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifc.f_rd_i = 0; ifc.f_pc_i = 0; ifc.f_priv_i = 0; ifc.f_abort_i = 0;
    ifc.p_rd_i = 0; ifc.p_pc_i = 0; ifc.p_priv_i = 0; ifc.p_abort_i = 0;
    ifc.flush_i = 0; ifc.ic_accept_i = 0; ifc.ic_valid_i = 0;
    ifc.ic_inst_i = 0; ifc.ic_error_i = 0; ifc.ic_page_fault_i = 0;
  endtask

  logic exp_f;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Busy-looking inputs while held in reset: every output must stay 0
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h55; ifc.ic_accept_i = 1;
    ifc.ic_valid_i = 1; ifc.ic_inst_i = 32'hDEAD_BEEF; ifc.ic_error_i = 1;
    mid();
    check("rst_ic_rd", 32'(ifc.ic_rd_o), 0);
    check("rst_f_accept", 32'(ifc.f_accept_o), 0);
    check("rst_ic_pc", ifc.ic_pc_o, 0);
    check("rst_rsp_inst", ifc.rsp_inst_o, 0);
    check("rst_rsp_err", 32'(ifc.rsp_error_o), 0);
    check("rst_f_valid", 32'(ifc.f_valid_o), 0);
    check("rst_ic_flush", 32'(ifc.ic_flush_o), 0);
    cyc(); cyc();
    clear_inputs();
    rst_n = 1'b1;
    ifc.ic_valid_i = 1;
    mid();
    check("idle_valid_f", 32'(ifc.f_valid_o), 0);
    check("idle_valid_p", 32'(ifc.p_valid_o), 0);
    cyc();
    ifc.ic_valid_i = 0;

    // Both ports requesting continuously
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h0000_0100;
    ifc.p_rd_i = 1; ifc.p_pc_i = 32'h0000_0206;
    ifc.ic_accept_i = 1;
    for (int g = 0; g < 4; g++) begin
`ifdef IC_ARB_RR_EN
      exp_f = (g % 2 == 0);
`else
      exp_f = 1'b1;
`endif
      mid();
      check($sformatf("alt%0d_f_accept", g), 32'(ifc.f_accept_o), 32'(exp_f));
      check($sformatf("alt%0d_p_accept", g), 32'(ifc.p_accept_o), 32'(!exp_f));
      check($sformatf("alt%0d_ic_pc", g), ifc.ic_pc_o, exp_f ? 32'h100 : 32'h204);
      cyc();
      mid();
      check($sformatf("alt%0d_busy_rd", g), 32'(ifc.ic_rd_o), 0);
      cyc();
      ifc.ic_valid_i = 1; ifc.ic_inst_i = 32'(g + 7);
      mid();
      check($sformatf("alt%0d_f_valid", g), 32'(ifc.f_valid_o), 32'(exp_f));
      check($sformatf("alt%0d_p_valid", g), 32'(ifc.p_valid_o), 32'(!exp_f));
      check($sformatf("alt%0d_bubble", g), 32'(ifc.f_accept_o | ifc.p_accept_o), 0);
      check($sformatf("alt%0d_rsp", g), ifc.rsp_inst_o, 32'(g + 7));
      cyc();
      ifc.ic_valid_i = 0;
    end
    clear_inputs();

    // Basic fetch with misaligned pc
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h0000_1003; ifc.f_priv_i = 2'b11; ifc.ic_accept_i = 1;
    mid();
    check("fetch_ic_pc", ifc.ic_pc_o, 32'h1000);
    check("fetch_ic_priv", 32'(ifc.ic_priv_o), 3);
    check("fetch_f_accept", 32'(ifc.f_accept_o), 1);
    check("fetch_p_accept", 32'(ifc.p_accept_o), 0);
    cyc();
    mid();
    check("fetch_busy_rd", 32'(ifc.ic_rd_o), 0);
    check("fetch_busy_acc", 32'(ifc.f_accept_o), 0);
    ifc.f_rd_i = 0;
    cyc(); cyc();
    ifc.ic_valid_i = 1; ifc.ic_inst_i = 32'h0000_0013; ifc.ic_page_fault_i = 1;
    mid();
    check("fetch_f_valid", 32'(ifc.f_valid_o), 1);
    check("fetch_rsp_inst", ifc.rsp_inst_o, 32'h13);
    check("fetch_rsp_pf", 32'(ifc.rsp_page_fault_o), 1);
    check("fetch_p_valid", 32'(ifc.p_valid_o), 0);
    cyc();
    clear_inputs();

    // Owner abort drops the response
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h2000; ifc.ic_accept_i = 1;
    mid();
    check("abort_grant", 32'(ifc.f_accept_o), 1);
    cyc();
    ifc.f_rd_i = 0; ifc.f_abort_i = 1;
    cyc();
    ifc.f_abort_i = 0; ifc.ic_valid_i = 1;
    mid();
    check("abort_f_valid", 32'(ifc.f_valid_o), 0);
    check("abort_p_valid", 32'(ifc.p_valid_o), 0);
    cyc();
    ifc.ic_valid_i = 0; ifc.f_rd_i = 1; ifc.ic_accept_i = 0;
    mid();
    check("abort_idle_rd", 32'(ifc.ic_rd_o), 1);
    cyc();
    clear_inputs();

    // Non-owner abort is ignored
    ifc.p_rd_i = 1; ifc.p_pc_i = 32'h3004; ifc.ic_accept_i = 1;
    mid();
    check("nabort_grant", 32'(ifc.p_accept_o), 1);
    cyc();
    ifc.p_rd_i = 0; ifc.f_abort_i = 1; ifc.ic_valid_i = 1;
    mid();
    check("nabort_p_valid", 32'(ifc.p_valid_o), 1);
    cyc();
    clear_inputs();

    // Flush during BUSY: response first, then two flush cycles, then grant resumes
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h4000; ifc.ic_accept_i = 1;
    mid();
    check("fl_grant", 32'(ifc.f_accept_o), 1);
    cyc();
    ifc.flush_i = 1;
    mid();
    check("fl_busy_flush", 32'(ifc.ic_flush_o), 0);
    cyc();
    ifc.flush_i = 0; ifc.ic_valid_i = 1;
    mid();
    check("fl_f_valid", 32'(ifc.f_valid_o), 1);
    cyc();
    ifc.ic_valid_i = 0;
    for (int k = 0; k < 2; k++) begin
      mid();
      check($sformatf("fl_hold%0d_flush", k), 32'(ifc.ic_flush_o), 1);
      check($sformatf("fl_hold%0d_acc", k), 32'(ifc.f_accept_o), 0);
      cyc();
    end
    mid();
    check("fl_done_flush", 32'(ifc.ic_flush_o), 0);
    check("fl_resume_acc", 32'(ifc.f_accept_o), 1);
    cyc();
    ifc.f_rd_i = 0;
    // Response coinciding with a flush pulse
    ifc.ic_valid_i = 1; ifc.flush_i = 1;
    mid();
    check("flco_f_valid", 32'(ifc.f_valid_o), 1);
    cyc();
    ifc.ic_valid_i = 0; ifc.flush_i = 0;
    mid();
    check("flco_flush", 32'(ifc.ic_flush_o), 1);
    cyc(); cyc();
    mid();
    check("flco_done", 32'(ifc.ic_flush_o), 0);
    // Flush in IDLE beats a request
    ifc.flush_i = 1; ifc.f_rd_i = 1; ifc.ic_accept_i = 1;
    mid();
    check("flidle_rd", 32'(ifc.ic_rd_o), 0);
    check("flidle_acc", 32'(ifc.f_accept_o), 0);
    cyc();
    ifc.flush_i = 0;
    mid();
    check("flidle_flush", 32'(ifc.ic_flush_o), 1);
    cyc(); cyc();
    clear_inputs();

    // Reset in the middle of BUSY
    ifc.f_rd_i = 1; ifc.f_pc_i = 32'h5000; ifc.ic_accept_i = 1;
    mid();
    check("rb_grant", 32'(ifc.f_accept_o), 1);
    cyc();
    rst_n = 1'b0;
    mid();
    check("rb_rst_rd", 32'(ifc.ic_rd_o), 0);
    check("rb_rst_acc", 32'(ifc.f_accept_o), 0);
    check("rb_rst_pc", ifc.ic_pc_o, 0);
    cyc();
    rst_n = 1'b1; ifc.f_rd_i = 0; ifc.ic_valid_i = 1;
    mid();
    check("rb_f_valid", 32'(ifc.f_valid_o), 0);
    check("rb_p_valid", 32'(ifc.p_valid_o), 0);
    cyc();
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
